// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: oversamples the camera bus on clk, pairs bytes into RGB565
// words and emits frame-buffer writes. Optional 2:1 decimation via OV7670_DECIMATE_EN.
module ov7670_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              pclk,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              frame_done,
  output logic              overflow
);

`ifdef OV7670_DECIMATE_EN
  localparam int FRAME_PIXELS = H_PIXELS * V_LINES / 4;
`else
  localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;

  state_t      state;
  logic [2:0]  pclk_sr, vsync_sr, href_sr;
  logic [7:0]  d_s1, d_s2, d_q;
  logic        pclk_rise, vs_rise, vs_fall, vs_q, href_q;
  logic        phase, wrote, full, keep_pixel;
  logic [7:0]  hi;

  // Edge detection is registered so the byte, href and vsync seen by the FSM
  // all come from the same sample of the camera bus.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pclk_sr   <= '0;
      vsync_sr  <= '0;
      href_sr   <= '0;
      d_s1      <= '0;
      d_s2      <= '0;
      d_q       <= '0;
      pclk_rise <= 1'b0;
      vs_rise   <= 1'b0;
      vs_fall   <= 1'b0;
      vs_q      <= 1'b0;
      href_q    <= 1'b0;
    end else begin
      pclk_sr   <= {pclk_sr[1:0], pclk};
      vsync_sr  <= {vsync_sr[1:0], vsync};
      href_sr   <= {href_sr[1:0], href};
      d_s1      <= d;
      d_s2      <= d_s1;
      d_q       <= d_s2;
      pclk_rise <= pclk_sr[1] & ~pclk_sr[2];
      vs_rise   <= vsync_sr[1] & ~vsync_sr[2];
      vs_fall   <= ~vsync_sr[1] & vsync_sr[2];
      vs_q      <= vsync_sr[1];
      href_q    <= href_sr[1];
    end
  end

`ifdef OV7670_DECIMATE_EN
  logic href_q2, line_odd, pix_odd;

  always_ff @(posedge clk) begin
    if (!resetn) href_q2 <= 1'b0;
    else         href_q2 <= href_q;
  end

  always_comb keep_pixel = ~(line_odd | pix_odd);
`else
  always_comb keep_pixel = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      we         <= 1'b0;
      addr       <= '0;
      dout       <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      phase      <= 1'b0;
      hi         <= '0;
      wrote      <= 1'b0;
      full       <= 1'b0;
`ifdef OV7670_DECIMATE_EN
      line_odd   <= 1'b0;
      pix_odd    <= 1'b0;
`endif
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      // Advance after each write; the last address is held and marked full.
      if (we) begin
        if (addr == LAST_ADDR) full <= 1'b1;
        else                   addr <= addr + 1'b1;
      end
      case (state)
        IDLE: begin
          phase <= 1'b0;
          if (enable && vs_rise) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          addr     <= '0;
          overflow <= 1'b0;
          phase    <= 1'b0;
          wrote    <= 1'b0;
          full     <= 1'b0;
`ifdef OV7670_DECIMATE_EN
          line_odd <= 1'b0;
`endif
          if (vs_fall) state <= ACTIVE;
        end
        ACTIVE: begin
          if (vs_rise) begin
            frame_done <= wrote;
            phase      <= 1'b0;
            state      <= enable ? WAIT_FRAME : IDLE;
          end else if (!href_q || vs_q) begin
            phase <= 1'b0;
          end else if (pclk_rise) begin
            if (!phase) begin
              hi    <= d_q;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (keep_pixel) begin
                if (full) begin
                  overflow <= 1'b1;
                end else begin
                  we    <= 1'b1;
                  dout  <= {hi, d_q};
                  wrote <= 1'b1;
                end
              end
`ifdef OV7670_DECIMATE_EN
              pix_odd <= ~pix_odd;
`endif
            end
          end
`ifdef OV7670_DECIMATE_EN
          if (href_q && !href_q2) pix_odd  <= 1'b0;
          if (!href_q && href_q2) line_odd <= ~line_odd;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed self-checking bench for ov7670_capture (H=4, V=2; V=4 when
// OV7670_DECIMATE_EN is defined).
module tb_ov7670_capture;

`ifdef OV7670_DECIMATE_EN
  localparam int V = 4;
`else
  localparam int V = 2;
`endif
  localparam int H  = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          resetn, enable, pclk, vsync, href;
  logic [7:0]    d;
  logic          we, frame_done, overflow;
  logic [AW-1:0] addr;
  logic [15:0]   dout;

  int checks = 0;
  int failures = 0;

  int            n_wr = 0;
  int            n_fd = 0;
  logic [AW-1:0] log_addr [0:63];
  logic [15:0]   log_data [0:63];

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .pclk(pclk), .vsync(vsync),
    .href(href), .d(d), .we(we), .addr(addr), .dout(dout),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      if (n_wr < 64) begin
        log_addr[n_wr] = addr;
        log_data[n_wr] = dout;
      end
      n_wr = n_wr + 1;
    end
    if (frame_done) n_fd = n_fd + 1;
  end

  function automatic logic [7:0] byte_at(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return 8'h12 + kb * 8'h22;
  endfunction

  function automatic logic [15:0] pix_at(input int k);
    return {byte_at(k), byte_at(k + 1)};
  endfunction

  task automatic cam_byte(input logic [7:0] b);
    d = b;
    pclk = 1'b0;
    repeat (4) @(negedge clk);
    pclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_line(input int start, input int nbytes);
    href = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbytes; i++) cam_byte(byte_at(start + i));
    href = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    repeat (8) @(negedge clk);
    vsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pclk = ~pclk; href = ~href; vsync = ~vsync; d = d + 8'h5A;
    end
    checks++; if (we !== 1'b0)       begin failures++; $display("FAIL reset_we got=%b want=0", we); end
    checks++; if (addr !== '0)       begin failures++; $display("FAIL reset_addr got=%h want=0", addr); end
    checks++; if (dout !== 16'h0)    begin failures++; $display("FAIL reset_dout got=%h want=0", dout); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    pclk = 1'b0; href = 1'b0; vsync = 1'b0; d = 8'h00;
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int bw, bf;
    enable = 1'b1;
    vsync_pulse();
    bw = n_wr; bf = n_fd;
    send_line(0, 2 * H);
    send_line(2 * H, 2 * H);
    checks++; if (n_wr - bw !== 8) begin failures++; $display("FAIL basic_count got=%0d want=8", n_wr - bw); end
    checks++; if (log_data[bw] !== 16'h1234) begin failures++; $display("FAIL basic_first got=%h want=1234", log_data[bw]); end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (log_addr[bw + j] !== AW'(j)) begin failures++; $display("FAIL basic_addr%0d got=%0d want=%0d", j, log_addr[bw + j], j); end
      checks++;
      if (log_data[bw + j] !== pix_at(2 * j)) begin failures++; $display("FAIL basic_data%0d got=%h want=%h", j, log_data[bw + j], pix_at(2 * j)); end
    end
    checks++; if (n_fd - bf !== 0) begin failures++; $display("FAIL basic_fd_early got=%0d want=0", n_fd - bf); end
    vsync_pulse();
    checks++; if (n_fd - bf !== 1) begin failures++; $display("FAIL basic_fd got=%0d want=1", n_fd - bf); end
  endtask

  task automatic test_enable_gating();
    int bw, bf;
    enable = 1'b0;
    bf = n_fd;
    vsync_pulse();
    checks++; if (n_fd - bf !== 0) begin failures++; $display("FAIL gate_empty_fd got=%0d want=0", n_fd - bf); end
    bw = n_wr; bf = n_fd;
    send_line(0, 2 * H);
    vsync_pulse();
    send_line(0, 2 * H);
    enable = 1'b1;
    send_line(2 * H, 2 * H);
    checks++; if (n_wr - bw !== 0) begin failures++; $display("FAIL gate_no_we got=%0d want=0", n_wr - bw); end
    checks++; if (n_fd - bf !== 0) begin failures++; $display("FAIL gate_no_fd got=%0d want=0", n_fd - bf); end
    vsync_pulse();
    bw = n_wr;
    send_line(0, 2 * H);
    checks++; if (n_wr - bw !== 4) begin failures++; $display("FAIL gate_resume_count got=%0d want=4", n_wr - bw); end
    checks++; if (log_addr[bw] !== '0) begin failures++; $display("FAIL gate_resume_addr got=%0d want=0", log_addr[bw]); end
    checks++; if (log_data[bw + 3] !== pix_at(6)) begin failures++; $display("FAIL gate_resume_data got=%h want=%h", log_data[bw + 3], pix_at(6)); end
    vsync_pulse();
    checks++; if (n_fd - bf !== 1) begin failures++; $display("FAIL gate_resume_fd got=%0d want=1", n_fd - bf); end
  endtask

  task automatic test_odd_bytes();
    int bw;
    bw = n_wr;
    send_line(20, 3);
    checks++; if (n_wr - bw !== 1) begin failures++; $display("FAIL odd_count got=%0d want=1", n_wr - bw); end
    send_line(30, 4);
    checks++; if (n_wr - bw !== 3) begin failures++; $display("FAIL odd_total got=%0d want=3", n_wr - bw); end
    checks++; if (log_data[bw] !== pix_at(20)) begin failures++; $display("FAIL odd_data0 got=%h want=%h", log_data[bw], pix_at(20)); end
    checks++; if (log_data[bw + 1] !== pix_at(30)) begin failures++; $display("FAIL odd_data1 got=%h want=%h", log_data[bw + 1], pix_at(30)); end
    checks++; if (log_data[bw + 2] !== pix_at(32)) begin failures++; $display("FAIL odd_data2 got=%h want=%h", log_data[bw + 2], pix_at(32)); end
    checks++; if (log_addr[bw + 2] !== AW'(2)) begin failures++; $display("FAIL odd_addr2 got=%0d want=2", log_addr[bw + 2]); end
    vsync_pulse();
  endtask

  task automatic test_overflow();
    int bw;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b want=0", overflow); end
    bw = n_wr;
    send_line(0, 2 * (H * V + 2));
    checks++; if (n_wr - bw !== H * V) begin failures++; $display("FAIL ovf_count got=%0d want=%0d", n_wr - bw, H * V); end
    checks++; if (log_addr[bw + H * V - 1] !== AW'(H * V - 1)) begin failures++; $display("FAIL ovf_last_addr got=%0d want=%0d", log_addr[bw + H * V - 1], H * V - 1); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", overflow); end
    checks++; if (addr !== AW'(H * V - 1)) begin failures++; $display("FAIL ovf_addr_hold got=%0d want=%0d", addr, H * V - 1); end
    vsync_pulse();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", overflow); end
  endtask

  task automatic test_decimate();
    int bw, bf;
    int k_exp [0:3];
    k_exp[0] = 0; k_exp[1] = 4; k_exp[2] = 16; k_exp[3] = 20;
    enable = 1'b1;
    vsync_pulse();
    bw = n_wr; bf = n_fd;
    for (int y = 0; y < V; y++) send_line(8 * y, 2 * H);
    checks++; if (n_wr - bw !== 4) begin failures++; $display("FAIL dec_count got=%0d want=4", n_wr - bw); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (log_addr[bw + j] !== AW'(j)) begin failures++; $display("FAIL dec_addr%0d got=%0d want=%0d", j, log_addr[bw + j], j); end
      checks++;
      if (log_data[bw + j] !== pix_at(k_exp[j])) begin failures++; $display("FAIL dec_data%0d got=%h want=%h", j, log_data[bw + j], pix_at(k_exp[j])); end
    end
    vsync_pulse();
    checks++; if (n_fd - bf !== 1) begin failures++; $display("FAIL dec_fd got=%0d want=1", n_fd - bf); end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; pclk = 1'b0; vsync = 1'b0; href = 1'b0; d = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
`ifdef OV7670_DECIMATE_EN
    test_decimate();
`else
    test_basic_frame();
    test_enable_gating();
    test_odd_bytes();
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
